// File: rtl/ram_handshake_controller_if.sv
// Control-unit to RAM handshake bundle: request, address, data and completion signals.
interface ram_handshake_controller_if;
  logic        ramMFA;
  logic        ramRW;
  logic [1:0]  ramDataSize;
  logic [8:0]  ramAddress;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        ramMFC;
  logic        alignError;
  logic        busy;

  modport master (
    output ramMFA, ramRW, ramDataSize, ramAddress, dataIn,
    input  dataOut, ramMFC, alignError, busy
  );

  modport slave (
    input  ramMFA, ramRW, ramDataSize, ramAddress, dataIn,
    output dataOut, ramMFC, alignError, busy
  );
endinterface

// File: rtl/ram_handshake_controller.sv
// Memory-side responder for the RAM handshake: big-endian byte-addressed RAM with
// byte/halfword/word access after a programmable wait, flagging illegal requests.
module ram_handshake_controller #(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                        Clk,
  input  logic                        reset,
  ram_handshake_controller_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [8:0]  addr_q;
  logic [31:0] din_q;
  logic        err_q;
  logic        req_err;
  logic        do_access;
  logic [8:0]  a1, a2, a3;
  logic [31:0] rdata;
  logic [7:0]  mem [DEPTH];

  // Unknown or illegal sizes fall through to the default and are rejected.
  always_comb begin
    req_err = 1'b1;
    case (bus.ramDataSize)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.ramAddress[0];
      2'b11:   req_err = |bus.ramAddress[1:0];
      default: req_err = 1'b1;
    endcase
  end

  // WAIT always lasts WAIT_CYCLES+1 edges (the completing edge included), so
  // WAIT_CYCLES=0 still passes through WAIT for one edge.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ramMFA) begin
          state_nx = WAIT;
          cnt_nx   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (!bus.ramMFA) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          state_nx  = DONE;
          do_access = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        if (!bus.ramMFA) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign a1 = addr_q + 9'd1;
  assign a2 = addr_q + 9'd2;
  assign a3 = addr_q + 9'd3;

  always_comb begin
    rdata = '0;
    case (size_q)
      2'b00:   rdata = {24'b0, mem[addr_q]};
      2'b01:   rdata = {16'b0, mem[addr_q], mem[a1]};
      default: rdata = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rw_q           <= 1'b0;
      size_q         <= '0;
      addr_q         <= '0;
      din_q          <= '0;
      err_q          <= 1'b0;
      bus.dataOut    <= '0;
      bus.ramMFC     <= 1'b0;
      bus.alignError <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && bus.ramMFA) begin
        rw_q   <= bus.ramRW;
        size_q <= bus.ramDataSize;
        addr_q <= bus.ramAddress;
        din_q  <= bus.dataIn;
        err_q  <= req_err;
      end
      if (do_access) begin
        bus.ramMFC     <= 1'b1;
        bus.alignError <= err_q;
        if (!err_q && !rw_q) bus.dataOut <= rdata;
      end else if (state == DONE && !bus.ramMFA) begin
        bus.ramMFC     <= 1'b0;
        bus.alignError <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; reset holds the FSM in IDLE so no write fires.
  always_ff @(posedge Clk) begin
    if (do_access && !err_q && rw_q) begin
      case (size_q)
        2'b00: mem[addr_q] <= din_q[7:0];
        2'b01: begin
          mem[addr_q] <= din_q[15:8];
          mem[a1]     <= din_q[7:0];
        end
        2'b11: begin
          mem[addr_q] <= din_q[31:24];
          mem[a1]     <= din_q[23:16];
          mem[a2]     <= din_q[15:8];
          mem[a3]     <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);

endmodule
